// File: rtl/puf_pkg.sv
// puf_pkg: shared types and defaults for the RO PUF sequencer.
//   puf_state_t : sequencer FSM states
//   DEF_*       : default parameter values
//   clog2       : ceil(log2(v)), used for select/index/timer widths
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } puf_state_t;

  localparam int DEF_NUM_RO        = 16;
  localparam int DEF_N_BITS        = 8;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_WINDOW_CYCLES = 1024;
  localparam int DEF_CNT_W         = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/puf_edge_counter.sv
// puf_edge_counter: saturating edge counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one edge this cycle
//   cnt        : current count, sticks at all-ones
module puf_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: sequences N_BITS pairwise RO comparisons per challenge.
//   clk, rst_n          : clock, async active-low reset
//   ena                 : enable; low aborts a run back to IDLE
//   start, challenge    : run request (sampled in IDLE) and 8-bit challenge
//   ro_a_edge/ro_b_edge : synchronized edge pulses from the selected ROs
//   ro_sel_a/ro_sel_b   : RO bank mux selects
//   ro_en               : RO enable, high in MEASURE only
//   busy, done          : not-idle flag, one-cycle completion pulse
//   response, tie       : last completed response word and tie flag
module ro_puf_ctrl
  import puf_pkg::*;
#(
  parameter int NUM_RO        = DEF_NUM_RO,
  parameter int N_BITS        = DEF_N_BITS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  localparam int SEL_W        = clog2(NUM_RO)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [7:0]        challenge,
  input  logic              ro_a_edge,
  input  logic              ro_b_edge,
  output logic [SEL_W-1:0]  ro_sel_a,
  output logic [SEL_W-1:0]  ro_sel_b,
  output logic              ro_en,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] response,
  output logic              tie
);

  localparam int IDX_W = (N_BITS > 1) ? clog2(N_BITS) : 1;
  localparam int TMAX  = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TMR_W = clog2(TMAX + 1);

  puf_state_t         state_q, state_d;
  logic [TMR_W-1:0]   tmr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         ch_q;
  logic [N_BITS-1:0]  shadow_q, shadow_nxt;
  logic               tie_sh_q, tie_nxt;
  logic [CNT_W-1:0]   cnt_a, cnt_b;
  logic               a_gt, a_eq;

  // next-selection inputs: in IDLE the pair for bit 0 comes straight from
  // the challenge pins, otherwise the pair for the following bit
  logic [7:0]         nsel_ch;
  logic [IDX_W-1:0]   nsel_idx;
  logic [7:0]         sum_a, sum_b;
  logic [SEL_W-1:0]   nsel_a, nsel_b;
  logic               start_run, next_bit, load_sel, finish;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && ena) state_d = S_SETTLE;
      S_SETTLE:  if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) state_d = S_MEASURE;
      S_MEASURE: if (tmr_q == TMR_W'(WINDOW_CYCLES - 1)) state_d = S_COMPARE;
      S_COMPARE: state_d = (idx_q == IDX_W'(N_BITS - 1)) ? S_DONE : S_SETTLE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // abort takes priority over every transition out of a busy state
    if (!ena && state_q != S_IDLE) state_d = S_IDLE;
  end

  assign start_run = (state_q == S_IDLE)    && (state_d == S_SETTLE);
  assign next_bit  = (state_q == S_COMPARE) && (state_d == S_SETTLE);
  assign finish    = (state_q == S_COMPARE) && (state_d == S_DONE);
  assign load_sel  = start_run || next_bit;

  // phase timer restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         tmr_q <= '0;
    else if (state_d != state_q || state_q == S_IDLE)  tmr_q <= '0;
    else                                                tmr_q <= tmr_q + 1'b1;
  end

  // ---------------- pair selection ----------------
  always_comb begin
    nsel_ch  = start_run ? challenge : ch_q;
    nsel_idx = start_run ? '0 : idx_q + 1'b1;
    sum_a    = 8'(nsel_ch[3:0]) + 8'(nsel_idx);
    sum_b    = 8'(nsel_ch[7:4]) + 8'(nsel_idx);
    nsel_a   = sum_a[SEL_W-1:0];
    nsel_b   = sum_b[SEL_W-1:0];
    // never compare an oscillator with itself
    if (nsel_a == nsel_b) nsel_b = nsel_a ^ SEL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_sel_a <= '0;
      ro_sel_b <= '0;
    end else if (load_sel) begin
      ro_sel_a <= nsel_a;
      ro_sel_b <= nsel_b;
    end
  end

  // ---------------- counters ----------------
  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == S_SETTLE),
    .en    (state_q == S_MEASURE && ro_a_edge),
    .cnt   (cnt_a)
  );

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == S_SETTLE),
    .en    (state_q == S_MEASURE && ro_b_edge),
    .cnt   (cnt_b)
  );

  // ---------------- compare / response ----------------
  assign a_gt    = cnt_a > cnt_b;
  assign a_eq    = cnt_a == cnt_b;
  assign tie_nxt = tie_sh_q | a_eq;

  always_comb begin
    shadow_nxt = shadow_q;
    for (int k = 0; k < N_BITS; k++)
      if (IDX_W'(k) == idx_q) shadow_nxt[k] = a_gt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q     <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      tie_sh_q <= 1'b0;
    end else if (start_run) begin
      ch_q     <= challenge;
      idx_q    <= '0;
      shadow_q <= '0;
      tie_sh_q <= 1'b0;
    end else if (next_bit || finish) begin
      shadow_q <= shadow_nxt;
      tie_sh_q <= tie_nxt;
      if (next_bit) idx_q <= idx_q + 1'b1;
    end
  end

  // response is published on the edge into DONE so it is already valid
  // in the cycle done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      response <= '0;
      tie      <= 1'b0;
    end else if (finish) begin
      response <= shadow_nxt;
      tie      <= tie_nxt;
    end
  end

  // status outputs registered from the next state: glitch-free ro_en and
  // all three track the state register cycle for cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ro_en <= (state_d == S_MEASURE);
      busy  <= (state_d != S_IDLE);
      done  <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
module tb_ro_puf_ctrl;

  localparam int P        = 11;      // 2 settle + 8 measure + 1 compare
  localparam int NB       = 4;
  localparam int DONE_CYC = NB * P + 1;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, start = 1'b0;
  logic [7:0] challenge = 8'h00;
  logic       ro_a_edge = 1'b0, ro_b_edge = 1'b0;

  logic [3:0] sel_a, sel_b, resp;
  logic       ro_en, busy, done, tie;
  logic [3:0] s_sel_a, s_sel_b, s_resp;
  logic       s_ro_en, s_busy, s_done, s_tie;

  int vecs = 0, errs = 0;
  int cyc  = 0;
  int mode_g = 0;

  ro_puf_ctrl #(.NUM_RO(16), .N_BITS(NB), .SETTLE_CYCLES(2), .WINDOW_CYCLES(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .challenge(challenge),
    .ro_a_edge(ro_a_edge), .ro_b_edge(ro_b_edge), .ro_sel_a(sel_a), .ro_sel_b(sel_b),
    .ro_en(ro_en), .busy(busy), .done(done), .response(resp), .tie(tie));

  ro_puf_ctrl #(.NUM_RO(16), .N_BITS(NB), .SETTLE_CYCLES(2), .WINDOW_CYCLES(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .challenge(challenge),
    .ro_a_edge(ro_a_edge), .ro_b_edge(ro_b_edge), .ro_sel_a(s_sel_a), .ro_sel_b(s_sel_b),
    .ro_en(s_ro_en), .busy(s_busy), .done(s_done), .response(s_resp), .tie(s_tie));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // edge pulse patterns, as a function of cycle number within a run
  task automatic drive_edges();
    int  off, b;
    logic a, bb;
    a = 1'b0; bb = 1'b0;
    if (cyc >= 1) begin
      off = (cyc - 1) % P;   // 0,1 settle; 2..9 measure; 10 compare
      b   = (cyc - 1) / P;
      case (mode_g)
        1: begin a = 1'b1; bb = (cyc % 2 == 0); end
        2: begin a = (cyc % 3 == 0); bb = a; end
        3: begin a = 1'b1; bb = (off == 2 || off == 3); end
        4: if (b % 2 == 0) begin a = 1'b1; bb = (cyc % 2 == 0); end
           else            begin a = (cyc % 2 == 0); bb = 1'b1; end
        5: begin a = (off == 9); bb = (off == 0 || off == 1 || off == 10); end
        6: begin a = 1'b1; bb = 1'b1; end
        default: ;
      endcase
    end
    ro_a_edge = a;
    ro_b_edge = bb;
  endtask

  task automatic tick();
    drive_edges();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // full run; after return the bench sits in the cycle after DONE (IDLE)
  task automatic run(input string name, input int m, input logic [7:0] ch,
                     input logic [3:0] e_resp, input logic e_tie, input logic chk_sel,
                     input logic chk_sat, input logic [3:0] e_sresp, input logic e_stie);
    logic early;
    early = 1'b0;
    mode_g = m; challenge = ch; cyc = 0; start = 1'b1;
    tick();
    while (cyc < DONE_CYC) begin
      if (chk_sel) begin
        if (cyc == 1)  begin chk({name, "_sel_a_b0"}, sel_a, 1); chk({name, "_sel_b_b0"}, sel_b, 2);
                             chk({name, "_ro_en_c1"}, ro_en, 0); end
        if (cyc == 3)  chk({name, "_ro_en_c3"}, ro_en, 1);
        if (cyc == 10) chk({name, "_ro_en_c10"}, ro_en, 1);
        if (cyc == 11) chk({name, "_ro_en_c11"}, ro_en, 0);
        if (cyc == 34) begin chk({name, "_sel_a_b3"}, sel_a, 4); chk({name, "_sel_b_b3"}, sel_b, 5); end
      end
      if (done) early = 1'b1;
      start = (cyc == 5);   // a start while busy must be ignored
      tick();
    end
    start = 1'b0;
    chk({name, "_early_done"}, early, 0);
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_last"}, busy, 1);
    chk({name, "_resp"}, resp, e_resp);
    chk({name, "_tie"}, tie, e_tie);
    if (chk_sat) begin
      chk({name, "_sat_resp"}, s_resp, e_sresp);
      chk({name, "_sat_tie"}, s_tie, e_stie);
    end
    tick();
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_done"}, done, 0);
  endtask

  initial begin
    logic seen;
    ena = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_done", done, 0);
    chk("rst_resp", resp, 0);
    chk("rst_tie", tie, 0);
    chk("rst_sel_a", sel_a, 0);
    chk("rst_sel_b", sel_b, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back runs: each starts in the cycle after the previous DONE
    run("basic",    1, 8'h21, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    run("pattern",  4, 8'h21, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    run("tie",      2, 8'h21, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    run("sat_tie",  6, 8'h21, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1);
    run("sat_gt",   3, 8'h21, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    run("boundary", 5, 8'h21, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // collision rule, then abort in cycle 20
    mode_g = 1; challenge = 8'h33; cyc = 0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("coll_sel_a_b0", sel_a, 3);
    chk("coll_sel_b_b0", sel_b, 2);
    while (cyc < 12) tick();
    chk("coll_sel_a_b1", sel_a, 4);
    chk("coll_sel_b_b1", sel_b, 5);
    while (cyc < 20) tick();
    chk("abort_ro_en_c20", ro_en, 1);
    ena = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_ro_en", ro_en, 0);
    seen = done;
    repeat (30) begin tick(); if (done) seen = 1'b1; end
    chk("abort_no_done", seen, 0);
    chk("abort_resp_hold", resp, 4'b1111);
    chk("abort_tie_hold", tie, 0);
    ena = 1'b1;

    // asynchronous reset mid-MEASURE
    mode_g = 1; challenge = 8'h21; cyc = 0; start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 15) tick();
    chk("rstm_ro_en_pre", ro_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_busy", busy, 0);
    chk("rstm_ro_en", ro_en, 0);
    chk("rstm_resp", resp, 0);
    chk("rstm_tie", tie, 0);
    chk("rstm_sel_a", sel_a, 0);
    chk("rstm_sel_b", sel_b, 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstm_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
